// File: rtl/rf_gpio_bridge.sv
// GPIO word to register-file bridge: toggle request/ack handshake, write registers,
// read strobes for clear-on-read sources, snapshot command and out-of-range error flag.
module rf_gpio_bridge #(
    parameter int unsigned NB_GPIO       = 32,
    parameter int unsigned NB_ADDR       = 9,
    parameter int unsigned NB_DATA       = 22,
    parameter int unsigned N_WR_REGS     = 32,
    parameter int unsigned N_RD_WORDS    = 64,
    parameter int unsigned SNAPSHOT_ADDR = (1 << (NB_ADDR - 1)) - 1
) (
    input  logic                            i_clock,
    input  logic                            i_reset,
    input  logic [NB_GPIO-1:0]              i_gpio_data,
    output logic [NB_GPIO-1:0]              o_gpio_data,
    output logic [N_WR_REGS*NB_DATA-1:0]    o_wr_data_bus,
    output logic [N_WR_REGS-1:0]            o_wr_pulse,
    input  logic [N_RD_WORDS*NB_DATA-1:0]   i_rd_data_bus,
    output logic [N_RD_WORDS-1:0]           o_rd_pulse,
    output logic                            o_snapshot
);

    localparam logic [NB_ADDR-1:0] WrLim    = NB_ADDR'(N_WR_REGS);
    localparam logic [NB_ADDR-1:0] RdLim    = NB_ADDR'(N_RD_WORDS);
    localparam logic [NB_ADDR-1:0] SnapAddr = NB_ADDR'(SNAPSHOT_ADDR);

    typedef enum logic [1:0] {StPrime, StIdle, StExec, StAck} state_e;

    state_e                  state_q, state_d;
    logic [1:0]              prime_cnt_q, prime_cnt_d;
    logic [NB_GPIO-1:0]      sync1_q, sync2_q;
    logic                    last_req_q, last_req_d;
    logic [NB_ADDR-1:0]      addr_q, addr_d;
    logic [NB_DATA-1:0]      data_q, data_d;
    logic [NB_DATA-1:0]      rd_hold_q, rd_hold_d;
    logic                    err_q, err_d;
    logic [NB_DATA-1:0]      wr_regs_q [N_WR_REGS];
    logic [NB_DATA-1:0]      wr_regs_d [N_WR_REGS];
    logic [N_WR_REGS-1:0]    wr_pulse_q, wr_pulse_d;
    logic [N_RD_WORDS-1:0]   rd_pulse_q, rd_pulse_d;
    logic                    snap_q, snap_d;
    logic [NB_GPIO-1:0]      gpio_out_q, gpio_out_d;

    logic                    req;
    logic [NB_ADDR-1:0]      gpio_addr;
    logic [NB_DATA-1:0]      gpio_data;
    logic                    is_read;
    logic [NB_ADDR-1:0]      rd_idx;
    logic                    prime_done;

    assign req        = sync2_q[NB_GPIO-1];
    assign gpio_addr  = sync2_q[NB_GPIO-2:NB_DATA];
    assign gpio_data  = sync2_q[NB_DATA-1:0];
    assign is_read    = addr_q[NB_ADDR-1];
    assign rd_idx     = {1'b0, addr_q[NB_ADDR-2:0]};
    // Stay in PRIME until sync2 holds a request level sampled after reset release.
    assign prime_done = (prime_cnt_q == 2'd2);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= StPrime;
            prime_cnt_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            prime_cnt_q <= prime_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        prime_cnt_d = prime_cnt_q;
        case (state_q)
            StPrime: begin
                if (prime_done) state_d = StIdle;
                else            prime_cnt_d = prime_cnt_q + 2'd1;
            end
            StIdle:  if (req != last_req_q) state_d = StExec;
            StExec:  state_d = StAck;
            StAck:   state_d = StIdle;
            default: state_d = StPrime;
        endcase
    end

    always_comb begin
        last_req_d = last_req_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rd_hold_d  = rd_hold_q;
        err_d      = err_q;
        gpio_out_d = gpio_out_q;
        wr_regs_d  = wr_regs_q;
        wr_pulse_d = '0;
        rd_pulse_d = '0;
        snap_d     = 1'b0;
        case (state_q)
            StPrime: begin
                if (prime_done) begin
                    last_req_d = req;
                    gpio_out_d = {req, {(NB_GPIO-1){1'b0}}};
                end
            end
            StIdle: begin
                if (req != last_req_q) begin
                    addr_d     = gpio_addr;
                    data_d     = gpio_data;
                    last_req_d = req;
                end
            end
            StExec: begin
                err_d     = 1'b0;
                rd_hold_d = '0;
                if (!is_read && addr_q < WrLim) begin
                    for (int k = 0; k < N_WR_REGS; k++) begin
                        if (addr_q == NB_ADDR'(k)) begin
                            wr_regs_d[k]  = data_q;
                            wr_pulse_d[k] = 1'b1;
                        end
                    end
                end else if (!is_read && addr_q == SnapAddr) begin
                    snap_d = 1'b1;
                end else if (is_read && rd_idx < RdLim) begin
                    for (int k = 0; k < N_RD_WORDS; k++) begin
                        if (rd_idx == NB_ADDR'(k)) begin
                            rd_hold_d     = i_rd_data_bus[k*NB_DATA +: NB_DATA];
                            rd_pulse_d[k] = 1'b1;
                        end
                    end
                end else begin
                    err_d = 1'b1;
                end
            end
            StAck: begin
                gpio_out_d = {last_req_q, err_q, {(NB_GPIO-NB_DATA-2){1'b0}}, rd_hold_q};
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            last_req_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            rd_hold_q  <= '0;
            err_q      <= 1'b0;
            gpio_out_q <= '0;
            wr_pulse_q <= '0;
            rd_pulse_q <= '0;
            snap_q     <= 1'b0;
            for (int k = 0; k < N_WR_REGS; k++) wr_regs_q[k] <= '0;
        end else begin
            sync1_q    <= i_gpio_data;
            sync2_q    <= sync1_q;
            last_req_q <= last_req_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rd_hold_q  <= rd_hold_d;
            err_q      <= err_d;
            gpio_out_q <= gpio_out_d;
            wr_pulse_q <= wr_pulse_d;
            rd_pulse_q <= rd_pulse_d;
            snap_q     <= snap_d;
            wr_regs_q  <= wr_regs_d;
        end
    end

    for (genvar g = 0; g < N_WR_REGS; g++) begin : g_wr_bus
        assign o_wr_data_bus[g*NB_DATA +: NB_DATA] = wr_regs_q[g];
    end

    assign o_gpio_data = gpio_out_q;
    assign o_wr_pulse  = wr_pulse_q;
    assign o_rd_pulse  = rd_pulse_q;
    assign o_snapshot  = snap_q;

endmodule

// File: tb/tb_rf_gpio_bridge.sv
// Scoreboard bench for rf_gpio_bridge: the driver queues expected ack words and pulses,
// a monitor pops and compares them whenever the bridge acks or pulses.
module tb_rf_gpio_bridge;

    localparam int NB_GPIO = 32;
    localparam int NB_ADDR = 9;
    localparam int NB_DATA = 22;
    localparam int N_WR    = 32;
    localparam int N_RD    = 64;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NB_GPIO-1:0]      gpio_in = '0;
    logic [NB_GPIO-1:0]      gpio_out;
    logic [N_WR*NB_DATA-1:0] wr_bus;
    logic [N_WR-1:0]         wr_pulse;
    logic [N_RD*NB_DATA-1:0] rd_bus;
    logic [N_RD-1:0]         rd_pulse;
    logic                    snap;

    rf_gpio_bridge dut (
        .i_clock       (clk),
        .i_reset       (rst_n),
        .i_gpio_data   (gpio_in),
        .o_gpio_data   (gpio_out),
        .o_wr_data_bus (wr_bus),
        .o_wr_pulse    (wr_pulse),
        .i_rd_data_bus (rd_bus),
        .o_rd_pulse    (rd_pulse),
        .o_snapshot    (snap)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Status sources; word 3 clears on the edge after its read strobe.
    logic [NB_DATA-1:0] src [N_RD];
    logic [NB_DATA-1:0] model_src [N_RD];
    logic               cleared3 = 1'b0;
    always @(posedge clk) if (rd_pulse[3]) cleared3 <= 1'b1;
    always_comb begin
        rd_bus = '0;
        for (int k = 0; k < N_RD; k++)
            rd_bus[k*NB_DATA +: NB_DATA] = (k == 3 && cleared3) ? '0 : src[k];
    end

    typedef struct {
        logic [NB_GPIO-1:0] gpio;
        int                 t0;
    } gexp_t;

    typedef struct {
        logic [N_WR-1:0]         wr;
        logic [N_RD-1:0]         rd;
        logic                    snap;
        logic [N_WR*NB_DATA-1:0] bus;
        int                      t0;
    } pexp_t;

    gexp_t gq[$];
    pexp_t pq[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    logic  req = 1'b1;
    logic [N_WR*NB_DATA-1:0] wr_model = '0;

    task automatic cmp(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event occurred, expected none", name);
    endtask

    task automatic push_prime_ack();
        gexp_t g;
        g.gpio = {req, {(NB_GPIO-1){1'b0}}};
        g.t0   = -1;
        gq.push_back(g);
    endtask

    task automatic xact(input logic [NB_ADDR-1:0] a, input logic [NB_DATA-1:0] d);
        gexp_t              g;
        pexp_t              p;
        logic               err;
        logic [NB_DATA-1:0] rdv;
        logic               pulse;
        int                 idx;
        int                 n;
        err    = 1'b0;
        rdv    = '0;
        pulse  = 1'b0;
        p.wr   = '0;
        p.rd   = '0;
        p.snap = 1'b0;
        gpio_in = {req, a, d};
        repeat (3) @(posedge clk);
        #1;
        req = ~req;
        gpio_in[NB_GPIO-1] = req;
        idx = int'(a[NB_ADDR-2:0]);
        if (!a[NB_ADDR-1] && idx < N_WR) begin
            p.wr[idx] = 1'b1;
            wr_model[idx*NB_DATA +: NB_DATA] = d;
            pulse = 1'b1;
        end else if (!a[NB_ADDR-1] && idx == 255) begin
            p.snap = 1'b1;
            pulse  = 1'b1;
        end else if (a[NB_ADDR-1] && idx < N_RD) begin
            p.rd[idx] = 1'b1;
            rdv = model_src[idx];
            if (idx == 3) model_src[3] = '0;
            pulse = 1'b1;
        end else begin
            err = 1'b1;
        end
        g.gpio = {req, err, 8'b0, rdv};
        g.t0   = cyc;
        gq.push_back(g);
        if (pulse) begin
            p.bus = wr_model;
            p.t0  = cyc;
            pq.push_back(p);
        end
        n = 0;
        while (gpio_out[NB_GPIO-1] !== req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) flag("ack_timeout");
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: pops on every ack toggle and every pulse.
    initial begin
        logic  prev_ack;
        gexp_t g;
        pexp_t p;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ack = 1'b0;
            end else begin
                if (gpio_out[NB_GPIO-1] !== prev_ack) begin
                    prev_ack = gpio_out[NB_GPIO-1];
                    if (gq.size() == 0) flag("unexpected_ack");
                    else begin
                        g = gq.pop_front();
                        cmp("gpio_word", gpio_out, g.gpio);
                        if (g.t0 >= 0) cmp("ack_latency", cyc - g.t0, 5);
                    end
                end
                if (|wr_pulse || |rd_pulse || snap) begin
                    if (pq.size() == 0) flag("unexpected_pulse");
                    else begin
                        p = pq.pop_front();
                        cmp("wr_pulse", wr_pulse, p.wr);
                        cmp("rd_pulse", rd_pulse, p.rd);
                        cmp("snapshot", snap, p.snap);
                        cmp("wr_bus", wr_bus, p.bus);
                        cmp("pulse_latency", cyc - p.t0, 4);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < N_RD; k++) begin
            src[k]       = '0;
            model_src[k] = '0;
        end
        src[3]        = 22'h012345;
        model_src[3]  = 22'h012345;
        src[63]       = 22'h3FFFFF;
        model_src[63] = 22'h3FFFFF;

        // Reset with the request bit left high.
        req     = 1'b1;
        gpio_in = {req, {(NB_GPIO-1){1'b0}}};
        repeat (3) @(posedge clk);
        #1;
        cmp("reset_gpio", gpio_out, 0);
        cmp("reset_wr_bus", wr_bus, 0);
        cmp("reset_pulses", {wr_pulse, rd_pulse, snap}, 0);
        push_prime_ack();
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        cmp("prime_ack", gpio_out, {1'b1, 31'b0});
        cmp("prime_wr_bus", wr_bus, 0);

        xact(9'd5,   22'h2AAAAA);
        xact(9'h103, 22'h000000);
        xact(9'h103, 22'h000000);
        xact(9'd40,  22'h1FFFFF);
        xact(9'h146, 22'h000000);
        xact(9'd255, 22'h3FFFFF);
        xact(9'd31,  22'h155555);
        xact(9'd32,  22'h0F0F0F);
        xact(9'h13F, 22'h000000);
        xact(9'h140, 22'h000000);
        xact(9'd0,   22'h000001);

        // Abort a write to register 1 just after the EXEC transition.
        gpio_in = {req, 9'd1, 22'h0155AA};
        repeat (3) @(posedge clk);
        #1;
        req = ~req;
        gpio_in[NB_GPIO-1] = req;
        repeat (3) @(posedge clk);
        #1;
        rst_n    = 1'b0;
        wr_model = '0;
        if (req) push_prime_ack();
        repeat (2) @(posedge clk);
        #1;
        cmp("abort_reset_gpio", gpio_out, 0);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        cmp("abort_prime_ack", gpio_out, {req, 31'b0});
        cmp("abort_wr_bus", wr_bus, 0);

        xact(9'd1, 22'h0ABCDE);
        xact(9'h13F, 22'h000000);

        repeat (10) @(posedge clk);
        #1;
        cmp("gpio_queue_drained", gq.size(), 0);
        cmp("pulse_queue_drained", pq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
